branch_predictor_bht: RTL and testbench

Dynamic branch predictor for the RV32I pipeline: it predicts conditional-branch direction and target at fetch. It is trained at execute by the resolved branch outcome from the branch condition logic. It combines a direct-mapped table of 2-bit saturating counters with a tagged target buffer and raises a mispredict/redirect indication when the resolved outcome differs from the prediction carried down the pipe.

---
 rtl/branch_predictor_bht.sv | 127 ++++++++++++
 tb/tb_branch_predictor_bht.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_bht.sv
// Direction/target predictor: 2-bit counters plus tagged targets, trained by resolved branches.
// Latency: lookup is combinational on PCF; training lands on the UpdateE edge, visible next cycle.
// Backpressure: none; every UpdateE cycle is one independent update and is always accepted.
module branch_predictor_bht #(
    parameter int IDX_BITS = 6,
    parameter int TAG_BITS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PCF,
    output logic        PredTakenF,
    output logic [31:0] PredTargetF,
    input  logic        UpdateE,
    input  logic [31:0] PCE,
    input  logic        TakenE,
    input  logic [31:0] TargetE,
    input  logic        PredTakenE,
    input  logic [31:0] PredTargetE,
    output logic        MispredictE,
    output logic [31:0] RedirectPCE,
    output logic [31:0] BranchCount,
    output logic [31:0] MispredCount
);

    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int TAG_LO  = IDX_BITS + 2;
    localparam int TAG_HI  = IDX_BITS + TAG_BITS + 1;

    typedef struct packed {
        logic                valid;
        logic [TAG_BITS-1:0] tag;
        logic [1:0]          ctr;
        logic [31:0]         target;
    } bht_entry_t;

    bht_entry_t table_q [ENTRIES];

    logic [IDX_BITS-1:0] idx_f;
    logic [TAG_BITS-1:0] tag_f;
    bht_entry_t          entry_f;
    logic                hit_f;

    logic [IDX_BITS-1:0] idx_e;
    logic [TAG_BITS-1:0] tag_e;
    bht_entry_t          entry_e;
    logic                hit_e;
    bht_entry_t          upd_entry;
    logic                upd_we;

    logic [31:0]         branch_count_q;
    logic [31:0]         mispred_count_q;

    // PC[1:0] and the bits above the tag never take part in index/tag matching.
    logic                unused_pc_bits;
    assign unused_pc_bits = ^{PCF[1:0], PCF[31:TAG_HI+1], PCE[1:0], PCE[31:TAG_HI+1]};

    // Fetch-side lookup reads stored state only, so a same-cycle update is not bypassed.
    assign idx_f   = PCF[IDX_BITS+1:2];
    assign tag_f   = PCF[TAG_HI:TAG_LO];
    assign entry_f = table_q[idx_f];
    assign hit_f   = entry_f.valid && (entry_f.tag == tag_f);

    assign PredTakenF  = hit_f & entry_f.ctr[1];
    assign PredTargetF = PredTakenF ? entry_f.target : (PCF + 32'd4);

    assign idx_e   = PCE[IDX_BITS+1:2];
    assign tag_e   = PCE[TAG_HI:TAG_LO];
    assign entry_e = table_q[idx_e];
    assign hit_e   = entry_e.valid && (entry_e.tag == tag_e);

    assign MispredictE = UpdateE & ((TakenE != PredTakenE) |
                                    (TakenE & (PredTargetE != TargetE)));
    assign RedirectPCE = TakenE ? TargetE : (PCE + 32'd4);

    always_comb begin
        upd_entry = entry_e;
        upd_we    = 1'b0;
        if (UpdateE) begin
            if (hit_e) begin
                upd_we = 1'b1;
                if (TakenE) begin
                    if (entry_e.ctr != 2'b11) begin
                        upd_entry.ctr = entry_e.ctr + 2'd1;
                    end
                    upd_entry.target = TargetE;
                end else if (entry_e.ctr != 2'b00) begin
                    upd_entry.ctr = entry_e.ctr - 2'd1;
                end
            end else if (TakenE) begin
                // Taken miss allocates over whatever alias is resident; not-taken misses leave it.
                upd_we           = 1'b1;
                upd_entry.valid  = 1'b1;
                upd_entry.tag    = tag_e;
                upd_entry.ctr    = 2'b10;
                upd_entry.target = TargetE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= '{valid: 1'b0, tag: '0, ctr: 2'b01, target: 32'd0};
            end
        end else if (upd_we) begin
            table_q[idx_e] <= upd_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            branch_count_q  <= 32'd0;
            mispred_count_q <= 32'd0;
        end else begin
            if (UpdateE) begin
                branch_count_q <= branch_count_q + 32'd1;
            end
            if (MispredictE) begin
                mispred_count_q <= mispred_count_q + 32'd1;
            end
        end
    end

    assign BranchCount  = branch_count_q;
    assign MispredCount = mispred_count_q;

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Scoreboard bench for branch_predictor_bht: a reference table model pushes expected outputs each cycle,
// and a negedge monitor pops and compares them against the DUT.
module tb_branch_predictor_bht;

    localparam int IDX = 6;
    localparam int TAG = 8;
    localparam int N   = 1 << IDX;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] PCF = 32'd0;
    logic        PredTakenF;
    logic [31:0] PredTargetF;
    logic        UpdateE = 1'b0;
    logic [31:0] PCE = 32'd0;
    logic        TakenE = 1'b0;
    logic [31:0] TargetE = 32'd0;
    logic        PredTakenE = 1'b0;
    logic [31:0] PredTargetE = 32'd0;
    logic        MispredictE;
    logic [31:0] RedirectPCE;
    logic [31:0] BranchCount;
    logic [31:0] MispredCount;

    branch_predictor_bht #(.IDX_BITS(IDX), .TAG_BITS(TAG)) dut (
        .clk(clk), .reset(reset), .PCF(PCF), .PredTakenF(PredTakenF), .PredTargetF(PredTargetF),
        .UpdateE(UpdateE), .PCE(PCE), .TakenE(TakenE), .TargetE(TargetE),
        .PredTakenE(PredTakenE), .PredTargetE(PredTargetE), .MispredictE(MispredictE),
        .RedirectPCE(RedirectPCE), .BranchCount(BranchCount), .MispredCount(MispredCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic        pt;
        logic [31:0] ptg;
        logic        mp;
        logic [31:0] rpc;
        logic [31:0] bc;
        logic [31:0] mc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    int checks = 0;
    int errors = 0;

    // Reference table
    logic            m_valid [N];
    logic [TAG-1:0]  m_tag   [N];
    logic [1:0]      m_ctr   [N];
    logic [31:0]     m_tgt   [N];
    logic [31:0]     m_bc;
    logic [31:0]     m_mc;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    function automatic logic [IDX-1:0] f_idx(input logic [31:0] pc);
        return pc[IDX+1:2];
    endfunction

    function automatic logic [TAG-1:0] f_tag(input logic [31:0] pc);
        return pc[IDX+TAG+1:IDX+2];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
            m_ctr[i]   = 2'b01;
            m_tgt[i]   = 32'd0;
        end
        m_bc = 32'd0;
        m_mc = 32'd0;
    endtask

    // One clock of stimulus: drive, push the expected outputs, then advance the model past the edge.
    task automatic cycle(input string name, input logic rst, input logic upd,
                         input logic [31:0] pcf, input logic [31:0] pce, input logic tk,
                         input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
        exp_t e;
        logic hit_f, hit_e, mp;
        logic [IDX-1:0] ie;
        @(posedge clk);
        #1;
        reset = rst; UpdateE = upd; PCF = pcf; PCE = pce;
        TakenE = tk; TargetE = tgt; PredTakenE = ptk; PredTargetE = ptgt;

        hit_f = m_valid[f_idx(pcf)] && (m_tag[f_idx(pcf)] == f_tag(pcf));
        mp    = upd && ((tk != ptk) || (tk && (ptgt != tgt)));
        e.tag = name;
        e.pt  = hit_f && m_ctr[f_idx(pcf)][1];
        e.ptg = e.pt ? m_tgt[f_idx(pcf)] : pcf + 32'd4;
        e.mp  = mp;
        e.rpc = tk ? tgt : pce + 32'd4;
        e.bc  = m_bc;
        e.mc  = m_mc;
        if (!rst) sb_q.push_back(e);

        if (rst) begin
            model_reset();
        end else if (upd) begin
            ie    = f_idx(pce);
            hit_e = m_valid[ie] && (m_tag[ie] == f_tag(pce));
            if (hit_e) begin
                if (tk) begin
                    if (m_ctr[ie] != 2'b11) m_ctr[ie] = m_ctr[ie] + 2'd1;
                    m_tgt[ie] = tgt;
                end else if (m_ctr[ie] != 2'b00) begin
                    m_ctr[ie] = m_ctr[ie] - 2'd1;
                end
            end else if (tk) begin
                m_valid[ie] = 1'b1;
                m_tag[ie]   = f_tag(pce);
                m_ctr[ie]   = 2'b10;
                m_tgt[ie]   = tgt;
            end
            m_bc = m_bc + 32'd1;
            if (mp) m_mc = m_mc + 32'd1;
        end
    endtask

    task automatic look(input string name, input logic [31:0] pcf);
        cycle(name, 1'b0, 1'b0, pcf, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    task automatic upd(input string name, input logic [31:0] pce, input logic tk,
                       input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
        cycle(name, 1'b0, 1'b1, pce, pce, tk, tgt, ptk, ptgt);
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            chk({mon_e.tag, ".pred_taken"},  {31'd0, PredTakenF},  {31'd0, mon_e.pt});
            chk({mon_e.tag, ".pred_target"}, PredTargetF,          mon_e.ptg);
            chk({mon_e.tag, ".mispredict"},  {31'd0, MispredictE}, {31'd0, mon_e.mp});
            if (mon_e.mp) chk({mon_e.tag, ".redirect"}, RedirectPCE, mon_e.rpc);
            chk({mon_e.tag, ".branch_cnt"},  BranchCount,          mon_e.bc);
            chk({mon_e.tag, ".mispred_cnt"}, MispredCount,         mon_e.mc);
        end
    end

    logic [31:0] pcs [6];

    initial begin
        pcs[0] = 32'h100; pcs[1] = 32'h200; pcs[2] = 32'h300;
        pcs[3] = 32'h104; pcs[4] = 32'h1FC; pcs[5] = 32'hFFFF_FFFC;
        model_reset();

        cycle("rst0", 1'b1, 1'b0, 32'h100, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        cycle("rst1", 1'b1, 1'b0, 32'h100, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        look("after_reset", 32'h100);

        // First taken branch: mispredict, allocate, fetch in same cycle still sees old state
        upd("alloc", 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        look("alloc_vis", 32'h100);

        // Counter walk: 10 -> 11 -> 11 -> 10 -> 01 -> 00 -> 01
        upd("tk1", 32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
        upd("tk2", 32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
        upd("nt1", 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
        look("after_nt1", 32'h100);
        upd("nt2", 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
        look("after_nt2", 32'h100);
        upd("nt3", 32'h100, 1'b0, 32'h80, 1'b0, 32'h104);
        upd("tk3", 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        look("after_tk3", 32'h100);

        // Aliasing at index 0
        cycle("rst_a", 1'b1, 1'b0, 32'h100, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        upd("alias_a", 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        upd("alias_b", 32'h200, 1'b1, 32'h300, 1'b0, 32'h204);
        look("alias_b_hit", 32'h200);
        look("alias_a_miss", 32'h100);
        upd("alias_c_nt", 32'h300, 1'b0, 32'h40, 1'b0, 32'h304);
        look("alias_b_kept", 32'h200);

        // Right direction, wrong target
        upd("wrong_tgt", 32'h200, 1'b1, 32'h90, 1'b1, 32'h80);
        look("tgt_fixed", 32'h200);

        // Reset beats a same-cycle taken update
        cycle("rst_upd", 1'b1, 1'b1, 32'h400, 32'h400, 1'b1, 32'h500, 1'b0, 32'h404);
        look("rst_upd_empty", 32'h400);
        look("rst_upd_old", 32'h200);

        // Wrapping PC+4 on both sides
        upd("wrap_nt", 32'hFFFF_FFFC, 1'b0, 32'h10, 1'b1, 32'h10);
        look("wrap_look", 32'hFFFF_FFFC);

        // Random traffic over a small aliasing PC set
        for (int i = 0; i < 300; i++) begin
            logic [31:0] pe, pf;
            logic tk, ptk;
            pe  = pcs[$urandom_range(0, 5)];
            pf  = pcs[$urandom_range(0, 5)];
            tk  = 1'($urandom_range(0, 1));
            ptk = 1'($urandom_range(0, 1));
            cycle("rand", 1'b0, 1'($urandom_range(0, 1)), pf, pe, tk,
                  32'h1000 + 32'($urandom_range(0, 3) * 16), ptk,
                  32'h1000 + 32'($urandom_range(0, 3) * 16));
        end

        look("final", 32'h100);
        repeat (3) @(posedge clk);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
